// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit driver and the frame-buffer controller above it.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package lcd_pkg;

    // Top-level sequencer states. The per-nibble SETUP/E/gap phases live in lcd_nibble_strobe.
    typedef enum logic [2:0] {
        S_POR  = 3'd0,   // power-on wait
        S_INIT = 3'd1,   // four init nibbles 3,3,3,2
        S_IDLE = 3'd2,   // waiting for write
        S_HI   = 3'd3,   // high nibble being strobed
        S_LO   = 3'd4,   // low nibble plus execute wait
        S_ACK  = 3'd5    // ack held until write drops
    } state_t;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_SETUP = 2'd1,
        P_E     = 2'd2,
        P_GAP   = 2'd3
    } phase_t;

    // Default timing in cycles of a 100 MHz clock.
    localparam int DEF_T_SETUP  = 4;
    localparam int DEF_T_EPULSE = 25;
    localparam int DEF_T_NGAP   = 100;
    localparam int DEF_T_CMD    = 4000;
    localparam int DEF_T_LONG   = 164000;
    localparam int DEF_T_POR    = 1500000;
    localparam int DEF_T_INIT1  = 410000;
    localparam int DEF_T_INIT2  = 10000;
    localparam int DEF_T_INIT3  = 4000;

    // Init nibbles: three "8-bit mode" wakeups, then the switch to 4-bit mode.
    localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    // Instruction bytes shared with the upstream controller.
    localparam logic [7:0] LCD_FUNC_SET    = 8'h28;
    localparam logic [7:0] LCD_ENTRY_MODE  = 8'h06;
    localparam logic [7:0] LCD_DISPLAY_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR       = 8'h01;
    localparam logic [7:0] LCD_LINE1       = 8'h80;
    localparam logic [7:0] LCD_LINE2       = 8'hC0;

    // Clear display (0x01) and return home (0x02/0x03) need the long execute wait.
    function automatic logic is_long(input logic [8:0] cmd);
        return (cmd[8] == 1'b0) && (cmd[7:2] == 6'd0) && (cmd[7:0] != 8'd0);
    endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// Emits one E-strobed nibble: SETUP (RS/D valid) -> E high -> caller-chosen gap, then done.
// Latency: T_SETUP + T_EPULSE + gap cycles from start to the done cycle.
// Backpressure: start is only taken when idle or on the done cycle (back-to-back nibbles).
// Ports: clock, reset (sync, active-high); start/nibble/rs/gap request a strobe, gap in cycles (>=1);
//        done is high on the last gap cycle; lcd_e/lcd_d/lcd_rs are registered pin drivers.
module lcd_nibble_strobe
    import lcd_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_EPULSE = DEF_T_EPULSE,
    parameter int CW       = 21
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    nibble,
    input  logic          rs,
    input  logic [CW-1:0] gap,
    output logic          done,
    output logic          lcd_e,
    output logic [3:0]    lcd_d,
    output logic          lcd_rs
);

    phase_t        phase, phase_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [CW-1:0] gap_q, gap_q_d;
    logic          e_d;
    logic [3:0]    d_d;
    logic          rs_d;

    // Kept out of the always_comb so the caller can feed start back without a false loop.
    assign done = (phase == P_GAP) && (cnt == '0);

    always_comb begin
        phase_d = phase;
        cnt_d   = (cnt != '0) ? cnt - CW'(1) : cnt;
        gap_q_d = gap_q;
        e_d     = lcd_e;
        d_d     = lcd_d;
        rs_d    = lcd_rs;
        case (phase)
            P_IDLE: ;
            P_SETUP: if (cnt == '0) begin
                phase_d = P_E;
                e_d     = 1'b1;
                cnt_d   = CW'(T_EPULSE - 1);
            end
            P_E: if (cnt == '0) begin
                phase_d = P_GAP;
                e_d     = 1'b0;
                cnt_d   = gap_q;
            end
            P_GAP: if (cnt == '0) phase_d = P_IDLE;
            default: begin
                phase_d = P_IDLE;
                e_d     = 1'b0;
            end
        endcase
        // Accepting on the done cycle lets the next SETUP follow the gap with no idle cycle.
        if (start && ((phase == P_IDLE) || done)) begin
            phase_d = P_SETUP;
            cnt_d   = CW'(T_SETUP - 1);
            gap_q_d = gap - CW'(1);
            d_d     = nibble;
            rs_d    = rs;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase  <= P_IDLE;
            cnt    <= '0;
            gap_q  <= '0;
            lcd_e  <= 1'b0;
            lcd_d  <= 4'h0;
            lcd_rs <= 1'b0;
        end else begin
            phase  <= phase_d;
            cnt    <= cnt_d;
            gap_q  <= gap_q_d;
            lcd_e  <= e_d;
            lcd_d  <= d_d;
            lcd_rs <= rs_d;
        end
    end

endmodule

// File: rtl/lcd_nibble_driver.sv
// HD44780 4-bit driver: power-on init, then one {RS,byte} command per write/ack handshake.
// Latency: accept -> ack = 1 + 2*(T_SETUP+T_EPULSE) + 2*T_NGAP + T_CMD (T_LONG for clear/home).
// Backpressure: write is held until ack; ack holds until write drops; no accept before init ends.
// Ports: clock, reset (sync, active-high); command[8]=RS, command[7:0]=byte; write request;
//        ack registered completion flag; LCD_D (DB7..DB4), LCD_E, LCD_RS registered; LCD_RW tied 0.
module lcd_nibble_driver
    import lcd_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_EPULSE = DEF_T_EPULSE,
    parameter int T_NGAP   = DEF_T_NGAP,
    parameter int T_CMD    = DEF_T_CMD,
    parameter int T_LONG   = DEF_T_LONG,
    parameter int T_POR    = DEF_T_POR,
    parameter int T_INIT1  = DEF_T_INIT1,
    parameter int T_INIT2  = DEF_T_INIT2,
    parameter int T_INIT3  = DEF_T_INIT3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] command,
    input  logic       write,
    output logic       ack,
    output logic [3:0] LCD_D,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW
);

    localparam int CW = $clog2(T_POR + 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    idx, idx_d;
    logic [8:0]    cmd_q;
    logic          cmd_ld;
    logic          ack_d;
    logic          start;
    logic [3:0]    st_nib;
    logic          st_rs;
    logic [CW-1:0] st_gap;
    logic          done;

    assign LCD_RW = 1'b0;

    always_comb begin
        state_d = state;
        cnt_d   = (cnt != '0) ? cnt - CW'(1) : cnt;
        idx_d   = idx;
        ack_d   = ack;
        cmd_ld  = 1'b0;
        start   = 1'b0;
        st_nib  = INIT_NIB_WAKE;
        st_rs   = 1'b0;
        st_gap  = CW'(T_INIT1);
        case (state)
            S_POR: if (cnt == '0) begin
                start   = 1'b1;
                idx_d   = 2'd0;
                state_d = S_INIT;
            end
            S_INIT: if (done) begin
                if (idx == 2'd3) begin
                    state_d = S_IDLE;
                end else begin
                    // idx names the nibble just finished; set up nibble idx+1.
                    start  = 1'b1;
                    idx_d  = idx + 2'd1;
                    st_nib = (idx == 2'd2) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
                    st_gap = (idx == 2'd0) ? CW'(T_INIT2) : CW'(T_INIT3);
                end
            end
            S_IDLE: if (write) begin
                // High nibble goes straight from the port; cmd_q supplies the rest later.
                cmd_ld  = 1'b1;
                start   = 1'b1;
                st_nib  = command[7:4];
                st_rs   = command[8];
                st_gap  = CW'(T_NGAP);
                state_d = S_HI;
            end
            S_HI: if (done) begin
                start   = 1'b1;
                st_nib  = cmd_q[3:0];
                st_rs   = cmd_q[8];
                // The low nibble's gap doubles as the execute wait.
                st_gap  = is_long(cmd_q) ? CW'(T_NGAP + T_LONG) : CW'(T_NGAP + T_CMD);
                state_d = S_LO;
            end
            S_LO: if (done) begin
                ack_d   = 1'b1;
                state_d = S_ACK;
            end
            S_ACK: if (!write) begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_POR;
                cnt_d   = CW'(T_POR - 1);
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_POR;
            cnt   <= CW'(T_POR - 1);   // primed so the power-on wait spans exactly T_POR cycles
            idx   <= 2'd0;
            cmd_q <= 9'd0;
            ack   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            ack   <= ack_d;
            if (cmd_ld) cmd_q <= command;
        end
    end

    lcd_nibble_strobe #(
        .T_SETUP  (T_SETUP),
        .T_EPULSE (T_EPULSE),
        .CW       (CW)
    ) u_strobe (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .nibble (st_nib),
        .rs     (st_rs),
        .gap    (st_gap),
        .done   (done),
        .lcd_e  (LCD_E),
        .lcd_d  (LCD_D),
        .lcd_rs (LCD_RS)
    );

endmodule

// File: tb/tb_lcd_nibble_driver.sv
module tb_lcd_nibble_driver;

    localparam int TS  = 2;
    localparam int TE  = 3;
    localparam int TG  = 5;
    localparam int TC  = 20;
    localparam int TL  = 60;
    localparam int TP  = 100;
    localparam int TI1 = 40;
    localparam int TI2 = 10;
    localparam int TI3 = 8;

    logic       clock;
    logic       reset;
    logic [8:0] command;
    logic       write;
    logic       ack;
    logic [3:0] LCD_D;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;

    lcd_nibble_driver #(
        .T_SETUP(TS), .T_EPULSE(TE), .T_NGAP(TG), .T_CMD(TC), .T_LONG(TL),
        .T_POR(TP), .T_INIT1(TI1), .T_INIT2(TI2), .T_INIT3(TI3)
    ) dut (
        .clock(clock), .reset(reset), .command(command), .write(write), .ack(ack),
        .LCD_D(LCD_D), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         rise;
        int         width;
        logic [3:0] d;
        logic       rs;
    } pulse_t;

    pulse_t pq[$];
    pulse_t cur;
    int     ackq[$];
    int     ackfq[$];
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     idle_from = 0;
    int     w_cyc = 0;
    int     viol = 0;
    int     n_pulses = 0;
    int     last_chg = -1000;
    int     last_fall = -1000;
    logic   e_prev = 1'b0;
    logic   a_prev = 1'b0;
    logic [4:0] rd_prev = 5'd0;

    // Cycle 0 is the first cycle after the last clock edge that saw reset high.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Pin monitor: records E pulses, ack edges and bus-stability violations.
    always @(negedge clock) begin
        if ({LCD_RS, LCD_D} !== rd_prev) begin
            if (LCD_E === 1'b1) viol++;
            if (cyc - last_fall < TG) viol++;
            last_chg = cyc;
            rd_prev  = {LCD_RS, LCD_D};
        end
        if (LCD_E === 1'b1 && !e_prev) begin
            cur.rise = cyc;
            cur.d    = LCD_D;
            cur.rs   = LCD_RS;
            if (cyc - last_chg < TS) viol++;
        end
        if (LCD_E === 1'b0 && e_prev) begin
            cur.width = cyc - cur.rise;
            pq.push_back(cur);
            n_pulses++;
            last_fall = cyc;
        end
        if (ack === 1'b1 && !a_prev) ackq.push_back(cyc);
        if (ack === 1'b0 && a_prev)  ackfq.push_back(cyc);
        e_prev = (LCD_E === 1'b1);
        a_prev = (ack === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        reset   = 1'b1;
        write   = 1'b0;
        command = 9'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checks++; if (ack !== 1'b0)    begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
        checks++; if (LCD_E !== 1'b0)  begin errors++; $display("FAIL reset_e: got %b want 0", LCD_E); end
        checks++; if (LCD_RS !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b want 0", LCD_RS); end
        checks++; if (LCD_RW !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", LCD_RW); end
        checks++; if (LCD_D !== 4'h0)  begin errors++; $display("FAIL reset_d: got %h want 0", LCD_D); end
    endtask

    // Expects to start in cycle 0 after a reset. Optionally raises write early to show it is ignored.
    task automatic test_init(input bit early);
        int     er[4];
        int     nib[4];
        int     gp[4];
        int     r;
        int     f;
        pulse_t p;
        nib = '{3, 3, 3, 2};
        gp  = '{TI1, TI2, TI3, TI3};
        r = TP + TS;
        f = 0;
        for (int i = 0; i < 4; i++) begin
            er[i] = r;
            f = r + TE;
            r = f + gp[i] + TS;
        end
        idle_from = f + TI3;
        if (early) begin
            while (cyc < 5) @(negedge clock);
            command = 9'h128;
            write   = 1'b1;
            w_cyc   = cyc;
        end
        while (cyc < idle_from) @(negedge clock);
        #1;
        checks++;
        if (ackq.size() != 0) begin errors++; $display("FAIL init_ack_quiet: got %0d ack rises want 0", ackq.size()); end
        checks++;
        if (pq.size() != 4) begin
            errors++; $display("FAIL init_pulse_count: got %0d want 4", pq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                p = pq.pop_front();
                checks++; if (p.rise != er[i]) begin errors++; $display("FAIL init_rise[%0d]: got %0d want %0d", i, p.rise, er[i]); end
                checks++; if (p.width != TE)   begin errors++; $display("FAIL init_width[%0d]: got %0d want %0d", i, p.width, TE); end
                checks++; if (p.d !== 4'(nib[i])) begin errors++; $display("FAIL init_d[%0d]: got %h want %h", i, p.d, nib[i]); end
                checks++; if (p.rs !== 1'b0)   begin errors++; $display("FAIL init_rs[%0d]: got %b want 0", i, p.rs); end
            end
        end
    endtask

    // One full handshake; called at a negedge. Model: accept, two nibbles, exec wait, ack.
    task automatic send_cmd(input logic [8:0] cmd, input logic [8:0] alt, input bit chg, input int hold);
        int     a, hr, lr, ar, af, wl, n;
        bit     lng;
        pulse_t p;
        if (!write) begin
            command = cmd;
            write   = 1'b1;
            w_cyc   = cyc;
        end
        a   = (w_cyc > idle_from) ? w_cyc : idle_from;
        hr  = a + 1 + TS;
        lr  = hr + TE + TG + TS;
        lng = (cmd[8] == 1'b0) && (cmd[7:0] != 8'd0) && (cmd[7:0] < 8'd4);
        ar  = lr + TE + TG + (lng ? TL : TC);
        n = 0;
        while (ack !== 1'b1 && n < 3000) begin
            @(negedge clock);
            n++;
            if (chg && cyc == a + 2) command = alt;
        end
        if (ack !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ack_timeout cmd=%h: no ack after %0d cycles", cmd, n);
            write = 1'b0;
            return;
        end
        repeat (hold) @(negedge clock);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ack_hold cmd=%h: got %b want 1", cmd, ack); end
        write = 1'b0;
        wl    = cyc;
        af    = wl + 1;
        n = 0;
        while (ack === 1'b1 && n < 10) begin @(negedge clock); n++; end
        #1;
        checks++;
        if (pq.size() != 2) begin
            errors++; $display("FAIL cmd_pulse_count cmd=%h: got %0d want 2", cmd, pq.size());
            pq.delete();
        end else begin
            p = pq.pop_front();
            checks++; if (p.rise != hr)      begin errors++; $display("FAIL hi_rise cmd=%h: got %0d want %0d", cmd, p.rise, hr); end
            checks++; if (p.width != TE)     begin errors++; $display("FAIL hi_width cmd=%h: got %0d want %0d", cmd, p.width, TE); end
            checks++; if (p.d !== cmd[7:4])  begin errors++; $display("FAIL hi_d cmd=%h: got %h want %h", cmd, p.d, cmd[7:4]); end
            checks++; if (p.rs !== cmd[8])   begin errors++; $display("FAIL hi_rs cmd=%h: got %b want %b", cmd, p.rs, cmd[8]); end
            p = pq.pop_front();
            checks++; if (p.rise != lr)      begin errors++; $display("FAIL lo_rise cmd=%h: got %0d want %0d", cmd, p.rise, lr); end
            checks++; if (p.width != TE)     begin errors++; $display("FAIL lo_width cmd=%h: got %0d want %0d", cmd, p.width, TE); end
            checks++; if (p.d !== cmd[3:0])  begin errors++; $display("FAIL lo_d cmd=%h: got %h want %h", cmd, p.d, cmd[3:0]); end
            checks++; if (p.rs !== cmd[8])   begin errors++; $display("FAIL lo_rs cmd=%h: got %b want %b", cmd, p.rs, cmd[8]); end
        end
        checks++;
        if (ackq.size() != 1) begin
            errors++; $display("FAIL ack_rise_count cmd=%h: got %0d want 1", cmd, ackq.size());
            ackq.delete();
        end else begin
            n = ackq.pop_front();
            if (n != ar) begin errors++; $display("FAIL ack_rise cmd=%h: got cycle %0d want %0d", cmd, n, ar); end
        end
        checks++;
        if (ackfq.size() != 1) begin
            errors++; $display("FAIL ack_fall_count cmd=%h: got %0d want 1", cmd, ackfq.size());
            ackfq.delete();
        end else begin
            n = ackfq.pop_front();
            if (n != af) begin errors++; $display("FAIL ack_fall cmd=%h: got cycle %0d want %0d", cmd, n, af); end
        end
        idle_from = af;
    endtask

    task automatic test_early_write();
        send_cmd(9'h128, 9'h128, 1'b0, 0);
    endtask

    task automatic test_long_cmds();
        send_cmd(9'h001, 9'h001, 1'b0, 0);
        send_cmd(9'h080, 9'h080, 1'b0, 2);
        send_cmd(9'h102, 9'h102, 1'b0, 1);
    endtask

    task automatic test_cmd_change();
        send_cmd(9'h141, 9'h142, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = n_pulses;
        send_cmd(9'h128, 9'h128, 1'b0, 0);
        send_cmd(9'h006, 9'h006, 1'b0, 0);
        send_cmd(9'h00C, 9'h00C, 1'b0, 0);
        repeat (20) @(negedge clock);
        #1;
        checks++; if (n_pulses - n0 != 6) begin errors++; $display("FAIL b2b_pulses: got %0d want 6", n_pulses - n0); end
        checks++; if (ackq.size() != 0)   begin errors++; $display("FAIL b2b_extra_ack: got %0d want 0", ackq.size()); end
    endtask

    task automatic test_random();
        logic [8:0] c;
        logic [8:0] alt;
        for (int i = 0; i < 20; i++) begin
            c = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0) c = 9'($urandom_range(1, 3));
            alt = 9'($urandom_range(0, 511));
            send_cmd(c, alt, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_stability();
        checks++; if (viol != 0) begin errors++; $display("FAIL bus_stability: got %0d violations want 0", viol); end
    endtask

    task automatic test_reset_mid();
        int   n;
        int   rises;
        logic pe;
        command = 9'h0C7;
        write   = 1'b1;
        n = 0; rises = 0; pe = LCD_E;
        while (rises < 2 && n < 500) begin
            @(negedge clock);
            n++;
            if (LCD_E === 1'b1 && !pe) rises++;
            pe = (LCD_E === 1'b1);
        end
        checks++;
        if (rises < 2) begin errors++; $display("FAIL mid_timeout: got %0d E rises want 2", rises); end
        checks++; if (LCD_D !== 4'h7) begin errors++; $display("FAIL mid_lo_nibble: got %h want 7", LCD_D); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        write = 1'b0;
        checks++; if (LCD_E !== 1'b0) begin errors++; $display("FAIL mid_reset_e: got %b want 0", LCD_E); end
        checks++; if (ack !== 1'b0)   begin errors++; $display("FAIL mid_reset_ack: got %b want 0", ack); end
        #1;
        pq.delete();
        ackq.delete();
        ackfq.delete();
        viol      = 0;
        last_fall = -1000;
        last_chg  = -1000;
    endtask

    initial begin
        test_reset();
        test_init(1'b1);
        test_early_write();
        test_long_cmds();
        test_cmd_change();
        test_back_to_back();
        test_random();
        test_stability();
        test_reset_mid();
        test_init(1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
